// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Bytes are accepted over a valid/ready handshake
// into a small FIFO. The serializer drains the FIFO and drives 8N1 (or 8N2)
// frames on ser_tx: start bit, 8 data bits LSB first, then stop bit(s).
// Consecutive frames abut with no idle gap while the FIFO is non-empty.
//
// Optional feature (macro UART_TX_PARITY_EN): an even-parity bit (XOR of the
// data bits) is inserted after data bit 7. Without the macro there is no
// parity logic at all.
//
// Parameters:
//   CLOCKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH      byte entries (power of two, >= 2)
//   STOP_BITS       stop bits per frame (1 or 2)
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       synchronous active-high reset
//   in_data     byte to transmit
//   in_valid    in_data valid
//   in_ready    FIFO can accept (registered count != FIFO_DEPTH)
//   ser_tx      registered serial line, idle high
//   busy        serializer not idle
//   fifo_count  current FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int STOP_BITS      = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLOCKS_PER_BIT);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DLY_LAST  = DW'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [3:0]    LAST_IDX  = 4'd8;
`else
  localparam logic [3:0]    LAST_IDX  = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;

  logic            push, pop, load, dly_last, fifo_nonempty;

  // in_ready depends only on the registered count, never on this cycle's pop,
  // so a full FIFO refuses a push even when a pop happens on the same edge.
  assign in_ready      = (cnt_q != FULL);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (cnt_q != '0);
  assign dly_last      = (dly_q == DLY_LAST);

  assign ser_tx     = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = cnt_q;

  // Serializer next-state logic
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = fifo_nonempty;
      end
      START: begin
        if (dly_last) begin
          dly_d   = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      DATA: begin
        if (dly_last) begin
          dly_d = '0;
          if (idx_q == LAST_IDX) begin
            // idx is reused as the stop-bit counter
            idx_d   = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
            tx_d    = (idx_q == 4'd7) ? par_q : shift_q[1];
`else
            tx_d    = shift_q[1];
`endif
          end
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      STOP: begin
        if (dly_last) begin
          dly_d = '0;
          if (idx_q != STOP_LAST) begin
            idx_d = idx_q + 4'd1;
          end else if (fifo_nonempty) begin
            // back-to-back: next start bit follows the last stop cycle directly
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      dly_d   = '0;
      idx_d   = '0;
      tx_d    = 1'b0;
      shift_d = mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_q];
`endif
    end
  end

  assign pop = load;

  // Control state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Data registers: no reset, contents are qualified by the control state
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPB = 8;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FBITS = 10 + PAR;          // default instance: one stop bit
  localparam int FLEN  = FBITS * CPB;
  localparam int F2LEN = 4 * (11 + PAR);    // second instance: CPB=4, 2 stop bits

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       rdy, tx, bsy;
  logic [2:0] cnt;

  logic [7:0] d2 = 8'h00;
  logic       v2 = 1'b0;
  logic       rdy2, tx2, bsy2;
  logic [2:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy), .ser_tx(tx), .busy(bsy), .fifo_count(cnt)
  );

  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clock(clk), .reset(rst), .in_data(d2), .in_valid(v2),
    .in_ready(rdy2), .ser_tx(tx2), .busy(bsy2), .fifo_count(cnt2)
  );

  // Reference model: a byte queue plus "which frame is on the line and how
  // many cycles into it are we". The line level is read off the frame's bit
  // list (start, data LSB first, optional parity, stop).
  byte unsigned mq[$];
  bit           m_busy = 1'b0;
  int           m_t = 0;
  byte unsigned m_cur = 8'h00;
  bit           m_push = 1'b0;
  int           m_pre;

  function automatic logic frame_bit(input byte unsigned b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic m_tx();
    return m_busy ? frame_bit(m_cur, m_t / CPB) : 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_push = 1'b0;
    end else begin
      m_pre  = mq.size();
      m_push = in_valid && (m_pre != DEP);
      if (m_busy && m_t != FLEN - 1) begin
        m_t++;
      end else if (m_pre != 0) begin
        m_cur  = mq.pop_front();
        m_busy = 1'b1;
        m_t    = 0;
      end else begin
        m_busy = 1'b0;
      end
      if (m_push) mq.push_back(in_data);
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; v2 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1)  begin n_err++; $display("FAIL reset ser_tx got %b exp 1", tx); end
    n_cmp++; if (bsy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b exp 0", bsy); end
    n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset fifo_count got %0d exp 0", cnt); end
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b exp 1", rdy); end
    n_cmp++; if (tx2 !== 1'b1 || bsy2 !== 1'b0 || cnt2 !== 3'd0)
      begin n_err++; $display("FAIL reset dut2 tx/busy/cnt got %b/%b/%0d exp 1/0/0", tx2, bsy2, cnt2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    for (int e = 0; e < FLEN + 20; e++) begin
      in_valid = (e == 0);
      in_data  = (e == 0) ? 8'h50 : 8'h00;
      @(negedge clk);
      n_cmp++; if (tx !== m_tx())    begin n_err++; $display("FAIL single ser_tx e=%0d got %b exp %b", e, tx, m_tx()); end
      n_cmp++; if (bsy !== m_busy)   begin n_err++; $display("FAIL single busy e=%0d got %b exp %b", e, bsy, m_busy); end
      n_cmp++; if (cnt !== 3'(mq.size())) begin n_err++; $display("FAIL single count e=%0d got %0d exp %0d", e, cnt, mq.size()); end
      if (e == 0) begin n_cmp++; if (cnt !== 3'd1) begin n_err++; $display("FAIL single count_e0 got %0d exp 1", cnt); end end
      if (e == 1) begin n_cmp++; if (tx !== 1'b0 || cnt !== 3'd0) begin n_err++; $display("FAIL single start_e1 tx/cnt got %b/%0d exp 0/0", tx, cnt); end end
      if (e == 8) begin n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL single start_e8 got %b exp 0", tx); end end
      if (e == 41) begin n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single bit4 got %b exp 1", tx); end end
      if (e == FLEN - CPB + 1) begin n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single stop got %b exp 1", tx); end end
      if (e == FLEN) begin n_cmp++; if (bsy !== 1'b1) begin n_err++; $display("FAIL single busy_last got %b exp 1", bsy); end end
      if (e == FLEN + 1) begin n_cmp++; if (bsy !== 1'b0) begin n_err++; $display("FAIL single busy_fall got %b exp 0", bsy); end end
    end
  endtask

  task automatic test_burst();
    byte unsigned msg[6] = '{8'h50, 8'h69, 8'h6E, 8'h67, 8'h21, 8'h0A};
    int k = 0;
    int acc_e[6] = '{default: -1};
    for (int e = 0; e < 6 * FLEN + 40; e++) begin
      in_valid = (k < 6);
      in_data  = (k < 6) ? msg[k] : 8'h00;
      @(negedge clk);
      if (m_push && k < 6) begin acc_e[k] = e; k++; end
      n_cmp++; if (tx !== m_tx())  begin n_err++; $display("FAIL burst ser_tx e=%0d got %b exp %b", e, tx, m_tx()); end
      n_cmp++; if (bsy !== m_busy) begin n_err++; $display("FAIL burst busy e=%0d got %b exp %b", e, bsy, m_busy); end
      n_cmp++; if (cnt !== 3'(mq.size()) || rdy !== (mq.size() != DEP))
        begin n_err++; $display("FAIL burst count/ready e=%0d got %0d/%b exp %0d", e, cnt, rdy, mq.size()); end
      if (e == 4) begin n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL burst ready_e4 got %b exp 0", rdy); end end
      if (e >= 1 && e <= 6 * FLEN) begin
        n_cmp++; if (bsy !== 1'b1) begin n_err++; $display("FAIL burst gap e=%0d busy got %b exp 1", e, bsy); end
      end
    end
    n_cmp++; if (acc_e[4] !== 4) begin n_err++; $display("FAIL burst accept5 edge got %0d exp 4", acc_e[4]); end
    n_cmp++; if (acc_e[5] !== FLEN + 2) begin n_err++; $display("FAIL burst accept6 edge got %0d exp %0d", acc_e[5], FLEN + 2); end
  endtask

  // mode 0: in_valid held high (full FIFO); mode 1: sparse random pushes
  task automatic test_random(input int mode, input int cycles);
    for (int e = 0; e < cycles + 5 * FLEN; e++) begin
      in_valid = (e < cycles) && (mode == 0 || $urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      @(negedge clk);
      n_cmp++; if (tx !== m_tx())  begin n_err++; $display("FAIL rand%0d ser_tx e=%0d got %b exp %b", mode, e, tx, m_tx()); end
      n_cmp++; if (bsy !== m_busy) begin n_err++; $display("FAIL rand%0d busy e=%0d got %b exp %b", mode, e, bsy, m_busy); end
      n_cmp++; if (cnt !== 3'(mq.size()) || rdy !== (mq.size() != DEP))
        begin n_err++; $display("FAIL rand%0d count/ready e=%0d got %0d/%b exp %0d", mode, e, cnt, rdy, mq.size()); end
      n_cmp++; if (cnt > 3'd4) begin n_err++; $display("FAIL rand%0d overflow got %0d exp <=4", mode, cnt); end
    end
  endtask

  task automatic test_reset_mid();
    byte unsigned b[3] = '{8'hA5, 8'h11, 8'h22};
    for (int e = 0; e < 300; e++) begin
      in_valid = (e < 3);
      in_data  = (e < 3) ? b[e] : 8'h00;
      rst      = (e == 31);
      @(negedge clk);
      if (e == 31) begin
        n_cmp++; if (tx !== 1'b1 || bsy !== 1'b0 || cnt !== 3'd0)
          begin n_err++; $display("FAIL rstmid after tx/busy/cnt got %b/%b/%0d exp 1/0/0", tx, bsy, cnt); end
      end
      if (e > 31) begin
        n_cmp++; if (tx !== 1'b1 || bsy !== 1'b0)
          begin n_err++; $display("FAIL rstmid idle e=%0d tx/busy got %b/%b exp 1/0", e, tx, bsy); end
      end
      n_cmp++; if (tx !== m_tx() || cnt !== 3'(mq.size()))
        begin n_err++; $display("FAIL rstmid model e=%0d tx/cnt got %b/%0d exp %b/%0d", e, tx, cnt, m_tx(), mq.size()); end
    end
    rst = 1'b0;
  endtask

  task automatic test_two_stop();
    logic tr[200];
    int first = -1, second = -1, lows = 0;
    for (int e = 0; e < 200; e++) begin
      v2 = (e < 2);
      d2 = (e == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      tr[e] = tx2;
    end
    v2 = 1'b0;
    for (int e = 1; e < 200; e++) begin
      if (tr[e-1] === 1'b1 && tr[e] === 1'b0) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
    end
    for (int e = 1; e <= F2LEN; e++) if (tr[e] === 1'b0) lows++;
    n_cmp++; if (first !== 1) begin n_err++; $display("FAIL stop2 first_start got %0d exp 1", first); end
    n_cmp++; if (second !== 1 + F2LEN) begin n_err++; $display("FAIL stop2 second_start got %0d exp %0d", second, 1 + F2LEN); end
    n_cmp++; if (lows !== 36 + 4 * PAR) begin n_err++; $display("FAIL stop2 low_cycles got %0d exp %0d", lows, 36 + 4 * PAR); end
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (tr[1 + F2LEN + 4 * k + 2] !== 1'b1)
        begin n_err++; $display("FAIL stop2 frame2 bit%0d got %b exp 1", k - 1, tr[1 + F2LEN + 4 * k + 2]); end
    end
    n_cmp++; if (tr[2 * F2LEN] !== 1'b1 || tr[2 * F2LEN + 5] !== 1'b1)
      begin n_err++; $display("FAIL stop2 trailing_idle got %b/%b exp 1/1", tr[2 * F2LEN], tr[2 * F2LEN + 5]); end
    n_cmp++; if (bsy2 !== 1'b0) begin n_err++; $display("FAIL stop2 busy_end got %b exp 0", bsy2); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic p1 = 1'bx, p2 = 1'bx;
    for (int e = 0; e < 2 * FLEN + 10; e++) begin
      in_valid = (e < 2);
      in_data  = (e == 0) ? 8'h03 : 8'h07;
      @(negedge clk);
      if (e == 1 + 9 * CPB + 4)        p1 = tx;
      if (e == 1 + FLEN + 9 * CPB + 4) p2 = tx;
      if (e == 1 + 2 * FLEN) begin
        n_cmp++; if (bsy !== 1'b0) begin n_err++; $display("FAIL parity busy_end got %b exp 0", bsy); end
      end
    end
    n_cmp++; if (p1 !== 1'b0) begin n_err++; $display("FAIL parity byte03 got %b exp 0", p1); end
    n_cmp++; if (p2 !== 1'b1) begin n_err++; $display("FAIL parity byte07 got %b exp 1", p2); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_random(0, 600);
    test_random(1, 1500);
    test_reset_mid();
    test_two_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serializes them onto a single TX line as 8N1 frames (start, 8 data LSB-first, stop).
- Sits downstream of the message/ping generators in the hx8k top. Consumes message_out/message_valid-style byte streams and drives SER_TX.
- Runs on the divided system clock (clock_8M); at 1 Mbaud, CLOCKS_PER_BIT = 8.

Parameters:
- CLOCKS_PER_BIT, 8: clock cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 4: byte entries; must be a power of two, >= 2.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; asserted when fifo_count != FIFO_DEPTH.
- ser_tx  out  1  serial line; idle high; registered.
- busy  out  1  high whenever the serializer state is not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous, active-high (reset). There is no asynchronous path.
- Reset values: ser_tx=1, busy=0, fifo_count=0, in_ready=1, state=IDLE. FIFO pointers are 0.
- Reset mid-frame: the frame is aborted and all FIFO contents are discarded. ser_tx is high from the cycle after the reset edge.
- Push: occurs on a clock edge where in_valid && in_ready.
  - in_ready is derived from the registered count only, with no combinational path from the pop.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- Pop: performed by the serializer only. A simultaneous push and pop leaves the count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- Serializer states: IDLE, START, DATA, STOP. Counters are bit_delay (0..CLOCKS_PER_BIT-1) and bit_index (0..7, or 0..8 with parity).
- IDLE:
  - ser_tx=1.
  - If fifo_count != 0: pop the head into a shift register, go to START, and set ser_tx<=0 on the same edge.
- START: hold ser_tx=0 for CLOCKS_PER_BIT cycles, then go to DATA with ser_tx<=shift[0].
- DATA:
  - Each bit is held for CLOCKS_PER_BIT cycles, LSB first.
  - After bit 7, go to STOP with ser_tx<=1.
- STOP:
  - Hold ser_tx=1 for STOP_BITS*CLOCKS_PER_BIT cycles.
  - On the final stop cycle, if the FIFO is non-empty, pop and enter START directly (back-to-back, no idle gap). Otherwise enter IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with the serializer IDLE is popped at edge N+1, so ser_tx falls at edge N+1.
- Frame length: exactly (10 + STOP_BITS - 1)*CLOCKS_PER_BIT cycles, or +CLOCKS_PER_BIT with parity. Consecutive frames abut exactly.
- Counter widths: bit_delay is $clog2(CLOCKS_PER_BIT) bits and wraps from CLOCKS_PER_BIT-1 to 0; bit_index is 4 bits.
- Data integrity: no byte is ever dropped or duplicated.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit(s). The parity is computed when the byte is popped. Frame length grows by CLOCKS_PER_BIT.
- Undefined: no parity state or logic exists; frames are pure 8N1/8N2.

Test Plan:
- Single byte (defaults): push 0x50 at edge 0.
  - ser_tx low for edges 1..8.
  - Then data bits 0,0,0,0,1,0,1,0, each 8 cycles.
  - Then high from edge 73.
  - busy falls at edge 81; fifo_count returns to 0 at edge 1.
- Burst "Ping!\n" (0x50 0x69 0x6E 0x67 0x21 0x0A) with in_valid held high from edge 0:
  - Five bytes are accepted at edges 0..4; in_ready is low after edge 4.
  - The sixth byte is accepted at edge 82, after the pop at edge 81.
  - ser_tx shows 6 contiguous frames, 480 cycles, no idle gaps, correct bytes in order.
- Full FIFO with in_valid held high and in_data changing every cycle:
  - fifo_count never exceeds 4.
  - Only bytes present on accepting edges appear on ser_tx, each exactly once.
- Reset asserted at edge 30 of a frame carrying 0xA5 with 2 bytes queued:
  - After the reset edge: ser_tx=1, busy=0, fifo_count=0.
  - No further start bit occurs until a new push.
- STOP_BITS=2, CLOCKS_PER_BIT=4, bytes 0x00 then 0xFF back-to-back:
  - Each frame is 44 cycles.
  - ser_tx is low for 36 cycles in frame 1.
  - The second start bit begins exactly 44 cycles after the first.
- With UART_TX_PARITY_EN, bytes 0x03 and 0x07:
  - Parity bit is 0 for 0x03 and 1 for 0x07.
  - Each frame is 88 cycles at defaults.
